// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit add slice reused per nibble,
// least-significant nibble first, with a registered ripple carry between passes.
module nibble_serial_adder #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned IDX_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8 || NIBBLES != WIDTH / 4) begin : g_bad_param
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 8, with NIBBLES = WIDTH/4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               out_valid_q;

    logic [IDX_W-1:0]   bit_idx_c;
    logic [3:0]         a_nib_c;
    logic [3:0]         b_nib_c;
    logic [4:0]         slice_c;
    logic               last_c;
    logic               ovf_c;

    // Shared 4-bit slice operating on the nibble selected by the counter
    always_comb begin
        bit_idx_c = {cnt_q, 2'b00};
        a_nib_c   = a_q[bit_idx_c +: 4];
        b_nib_c   = b_q[bit_idx_c +: 4];
        slice_c   = 5'(a_nib_c) + 5'(b_nib_c) + 5'(carry_q);
        last_c    = (cnt_q == LAST_NIB);
        // b_q already holds ~b in subtract mode, so one rule covers both modes
        ovf_c     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_c[3] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    sum_q[bit_idx_c +: 4] <= slice_c[3:0];
                    carry_q               <= slice_c[4];
                    if (last_c) begin
                        cout_q      <= slice_c[4];
                        ovf_q       <= ovf_c;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder (WIDTH = 16) against an
// arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] ms, output logic mc, output logic mo);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            ures = ua - ub;
            sres = sa - sb;
            mc   = (ua >= ub);
        end else begin
            ures = ua + ub + int'(mcin);
            sres = sa + sb + int'(mcin);
            mc   = (ures > 65535);
        end
        ms = ures[W-1:0];
        mo = (sres > 32767) || (sres < -32768);
    endfunction

    // Drive one operation, release the result, report what was observed
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xcin, input logic xsub,
                         output logic [W-1:0] s, output logic c, output logic o,
                         output int lat, output logic rdy_after);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum; c = cout; o = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++;
        if ({sum, cout, ovf} !== {W'(0), 2'b00})
            $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b exp 0/0/0", sum, cout, ovf);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        logic [W-1:0] tb [5] = '{16'h0FCD, 16'h0001, 16'h0001, 16'h0001, 16'h0002};
        logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [5] = '{16'h2201, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] s;
        logic         c, o, r;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], tc[i], ts[i], s, c, o, lat, r);
            total_cnt++;
            if (lat !== 4) $display("FAIL dir%0d_latency got %0d exp 4", i, lat); else pass_cnt++;
            total_cnt++;
            if ({s, c, o} !== {es[i], ec[i], eo[i]})
                $display("FAIL dir%0d_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                         i, s, c, o, es[i], ec[i], eo[i]);
            else pass_cnt++;
            total_cnt++;
            if (r !== 1'b1) $display("FAIL dir%0d_idle_after got in_ready=%b exp 1", i, r); else pass_cnt++;
        end
    endtask

    task automatic test_random;
        logic [W-1:0] xa, xb, s, es;
        logic         xc, xs, c, o, ec, eo, r;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            xa = W'($urandom); xb = W'($urandom);
            xc = 1'($urandom); xs = 1'($urandom);
            model(xa, xb, xc, xs, es, ec, eo);
            do_op(xa, xb, xc, xs, s, c, o, lat, r);
            total_cnt++;
            if (lat !== 4 || {s, c, o} !== {es, ec, eo})
                $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=4",
                         i, xa, xb, xc, xs, s, c, o, lat, es, ec, eo);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure;
        int guard;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL bp_out_valid_rise got %b exp 1", out_valid); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            total_cnt++;
            if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 16'h2345})
                $display("FAIL bp_hold%0d got out_valid=%b in_ready=%b sum=%h exp 1/0/2345",
                         i, out_valid, in_ready, sum);
            else pass_cnt++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h2345})
            $display("FAIL bp_release got out_valid=%b in_ready=%b sum=%h exp 0/1/2345",
                     out_valid, in_ready, sum);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc;
        logic [W-1:0] s;
        logic         c, o, r, seen;
        int           lat;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, W'(0)})
            $display("FAIL midrst_state got in_ready=%b out_valid=%b sum=%h exp 1/0/0000",
                     in_ready, out_valid, sum);
        else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL midrst_no_pulse got out_valid seen=%b exp 0", seen); else pass_cnt++;
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, s, c, o, lat, r);
        total_cnt++;
        if ({s, c, o} !== {16'h0007, 2'b00} || lat !== 4)
            $display("FAIL midrst_recover got sum=%h cout=%b ovf=%b lat=%0d exp 0007/0/0/4", s, c, o, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            model(a, b, cin, sub, es, ec, eo);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = '0; b = '0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            total_cnt++;
            if (lat !== 4 || {sum, cout, ovf} !== {es, ec, eo})
                $display("FAIL b2b%0d_result got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=4",
                         k, sum, cout, ovf, lat, es, ec, eo);
            else pass_cnt++;
            // New operand offered while DONE; it must wait for the IDLE cycle
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            total_cnt++;
            if ({out_valid, in_ready} !== 2'b01)
                $display("FAIL b2b%0d_one_cycle got out_valid=%b in_ready=%b exp 0/1", k, out_valid, in_ready);
            else pass_cnt++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid_calc;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
